stack_ext: RTL and testbench
============================

// Module: stack_ext
// PURPOSE
//  Parametrised signed LIFO stack, successor to the single-mode stack. Adds occupancy count,
//  combinational peek of top, same-cycle push+pop (replace-top), almost_full threshold,
//  sticky overflow/underflow error flags, synchronous clear and a pop-data valid strobe.
//  Sits between an expression/operand producer and an arithmetic consumer; one clock domain.
// PARAMETERS
//  N          8   data width in bits (signed), >=1
//  DEPTH      16  number of entries, >=2, need not be a power of two
//  AF_THRESH  12  almost_full asserted when count >= AF_THRESH; 1..DEPTH
// PORTS
//  clk          in   1        rising-edge clock
//  rst_n        in   1        asynchronous, active-low reset
//  clear        in   1        synchronous clear; priority over push/pop
//  push         in   1        write data_in onto stack
//  pop          in   1        remove top entry into data_out
//  data_in      in   N        signed push data
//  data_out     out  N        signed registered pop data
//  data_valid   out  1        1-cycle strobe: data_out updated by a pop this cycle
//  top          out  N        combinational peek of top entry; 0 when empty
//  count        out  CW       occupancy, CW = $clog2(DEPTH+1); range 0..DEPTH
//  full         out  1        count == DEPTH
//  empty        out  1        count == 0
//  almost_full  out  1        count >= AF_THRESH
//  overflow     out  1        sticky: push rejected because full
//  underflow    out  1        sticky: pop found empty
// BEHAVIOUR
//  Reset (rst_n low, async): count=0, data_out=0, data_valid=0, overflow=0, underflow=0.
//   Memory array not reset. full/empty/almost_full/top are pure decodes of count+memory.
//  Operations per rising edge, evaluated on current count (priority top-down):
//   clear: count<=0, overflow<=0, underflow<=0, data_valid<=0; data_out holds.
//   push&pop, !empty: data_out<=mem[count-1], mem[count-1]<=data_in, count unchanged,
//    data_valid<=1. Legal when full; no overflow.
//   push&pop, empty: behaves as push (mem[0]<=data_in, count<=1), underflow<=1, data_valid<=0.
//   push only, !full: mem[count]<=data_in, count<=count+1.
//   push only, full: ignored, overflow<=1, count unchanged.
//   pop only, !empty: data_out<=mem[count-1], count<=count-1, data_valid<=1.
//   pop only, empty: ignored, underflow<=1, data_out holds.
//   idle: state holds.
//  data_valid is 0 in every cycle not listed as setting it (strobe, never sticky).
//  Latency: pop -> data_out/data_valid 1 cycle. push -> visible on top 1 cycle.
//  count width CW allows count==DEPTH; no modulo wrap, no index aliasing for any DEPTH.
//  overflow/underflow clear only on reset or clear; not on subsequent legal ops.
//  No arithmetic on data: values stored and returned bit-exact, sign preserved.
//  Reset mid-operation: async, takes effect immediately; in-flight push/pop discarded.
// TESTING  (N=8, DEPTH=4, AF_THRESH=3)
//  Reset, push 5,-3,127,-128 -> count 4, full=1, almost_full=1 from 3rd push, top=-128.
//  5th push 9 while full -> count 4, overflow=1, top=-128; pops return -128,127,-3,5
//   each with data_valid 1 cycle later, then empty=1, top=0.
//  Pop while empty -> underflow=1, data_valid=0, data_out holds 5; clear -> underflow=0.
//  Stack [1,2]; push 7 & pop same cycle -> data_out=2, data_valid=1, count 2, top=7.
//  Empty; push 4 & pop -> count 1, top=4, underflow=1, data_valid=0.
//  Push 3 values, assert rst_n low mid-cycle -> count=0, flags=0, data_valid=0 immediately.

Source files
------------

// File: rtl/stack_ext.sv
// stack_ext: signed LIFO with occupancy, peek, replace-top, almost_full, sticky errors and pop strobe
module stack_ext #(
    parameter int N         = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 12,
    localparam int CW       = $clog2(DEPTH + 1),
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear_i,
    input  logic                push_i,
    input  logic                pop_i,
    input  logic signed [N-1:0] data_in_i,
    output logic signed [N-1:0] data_out_o,
    output logic                data_valid_o,
    output logic signed [N-1:0] top_o,
    output logic [CW-1:0]       count_o,
    output logic                full_o,
    output logic                empty_o,
    output logic                almost_full_o,
    output logic                overflow_o,
    output logic                underflow_o
);
    logic [N-1:0]  mem_q [DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic [N-1:0]  data_out_q, data_out_d;
    logic          valid_q, valid_d, ovf_q, ovf_d, unf_q, unf_d;
    logic          do_rep, do_push, do_pop;
    logic [AW-1:0] rd_idx, wr_idx;

    // count never exceeds DEPTH, so count-1 and (count when not full) both fit AW bits
    always_comb begin
        empty_o       = count_q == '0;
        full_o        = count_q == CW'(DEPTH);
        almost_full_o = count_q >= CW'(AF_THRESH);
        rd_idx        = AW'(count_q - CW'(1));
        do_rep        = !clear_i && push_i && pop_i && !empty_o;
        do_push       = !clear_i && push_i && (pop_i ? empty_o : !full_o);
        do_pop        = !clear_i && pop_i && !push_i && !empty_o;
        wr_idx        = do_rep ? rd_idx : AW'(count_q);
        count_d       = clear_i ? '0 : do_push ? count_q + CW'(1) : do_pop ? count_q - CW'(1) : count_q;
        data_out_d    = (do_rep || do_pop) ? mem_q[rd_idx] : data_out_q;
        valid_d       = do_rep || do_pop;
        ovf_d         = !clear_i && (ovf_q || (push_i && !pop_i && full_o));
        unf_d         = !clear_i && (unf_q || (pop_i && empty_o));
        top_o         = empty_o ? '0 : mem_q[rd_idx];
    end

    always_ff @(posedge clk) begin
        if (do_rep || do_push) mem_q[wr_idx] <= data_in_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            count_q    <= count_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    assign count_o      = count_q;
    assign data_out_o   = data_out_q;
    assign data_valid_o = valid_q;
    assign overflow_o   = ovf_q;
    assign underflow_o  = unf_q;
endmodule

// File: tb/tb_stack_ext.sv
// tb_stack_ext: directed vector table, mid-cycle reset sequence and random run against a queue model
module tb_stack_ext;
    localparam int N = 8, DEPTH = 4, AF = 3, CW = $clog2(DEPTH + 1);
    logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, push = 1'b0, pop = 1'b0;
    logic signed [N-1:0] din = '0, dout, top;
    logic [CW-1:0] cnt;
    logic dv, full, empty, af, ovf, unf;
    int vectors = 0, miscompares = 0;

    stack_ext #(.N(N), .DEPTH(DEPTH), .AF_THRESH(AF)) dut (
        .clk(clk), .rst_n(rst_n), .clear_i(clear), .push_i(push), .pop_i(pop),
        .data_in_i(din), .data_out_o(dout), .data_valid_o(dv), .top_o(top),
        .count_o(cnt), .full_o(full), .empty_o(empty), .almost_full_o(af),
        .overflow_o(ovf), .underflow_o(unf));

    always #5 clk = ~clk;

    typedef struct {
        bit clr, psh, pp;
        int din, cnt, top, dout;
        bit dv, ovf, unf;
    } vec_t;
    vec_t tbl[$];

    // reference model: a queue whose back is the top of the stack
    int q[$];
    int dout_m = 0;
    bit dv_m = 0, ovf_m = 0, unf_m = 0;

    function automatic vec_t mk(bit c, bit p, bit o, int d, int n, int t, int od, bit v, bit ov, bit un);
        vec_t r;
        r.clr = c; r.psh = p; r.pp = o; r.din = d; r.cnt = n; r.top = t;
        r.dout = od; r.dv = v; r.ovf = ov; r.unf = un;
        return r;
    endfunction

    task automatic chk(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(string tag, int n, int t, int od, bit v, bit ov, bit un);
        chk({tag, " count"}, int'(cnt), n);
        chk({tag, " top"}, int'(top), t);
        chk({tag, " data_out"}, int'(dout), od);
        chk({tag, " data_valid"}, int'(dv), int'(v));
        chk({tag, " overflow"}, int'(ovf), int'(ov));
        chk({tag, " underflow"}, int'(unf), int'(un));
        chk({tag, " full"}, int'(full), int'(n == DEPTH));
        chk({tag, " empty"}, int'(empty), int'(n == 0));
        chk({tag, " almost_full"}, int'(af), int'(n >= AF));
    endtask

    task automatic model_reset();
        q.delete();
        dout_m = 0; dv_m = 0; ovf_m = 0; unf_m = 0;
    endtask

    task automatic model_step(bit c, bit p, bit o, int d);
        dv_m = 0;
        if (c) begin
            q.delete(); ovf_m = 0; unf_m = 0;
        end else if (p && o) begin
            if (q.size() > 0) begin
                dout_m = q[q.size()-1]; q[q.size()-1] = d; dv_m = 1;
            end else begin
                q.push_back(d); unf_m = 1;
            end
        end else if (p) begin
            if (q.size() < DEPTH) q.push_back(d);
            else ovf_m = 1;
        end else if (o) begin
            if (q.size() > 0) begin
                dout_m = q.pop_back(); dv_m = 1;
            end else unf_m = 1;
        end
    endtask

    task automatic apply(bit c, bit p, bit o, int d);
        @(negedge clk);
        clear = c; push = p; pop = o; din = N'(d);
        @(posedge clk);
        #1;
        model_step(c, p, o, $signed(din));
    endtask

    initial begin
        tbl.push_back(mk(0,1,0,   5, 1,    5,    0, 0, 0, 0));
        tbl.push_back(mk(0,1,0,  -3, 2,   -3,    0, 0, 0, 0));
        tbl.push_back(mk(0,1,0, 127, 3,  127,    0, 0, 0, 0));
        tbl.push_back(mk(0,1,0,-128, 4, -128,    0, 0, 0, 0));
        tbl.push_back(mk(0,1,0,   9, 4, -128,    0, 0, 1, 0));
        tbl.push_back(mk(0,0,1,   0, 3,  127, -128, 1, 1, 0));
        tbl.push_back(mk(0,0,1,   0, 2,   -3,  127, 1, 1, 0));
        tbl.push_back(mk(0,0,1,   0, 1,    5,   -3, 1, 1, 0));
        tbl.push_back(mk(0,0,1,   0, 0,    0,    5, 1, 1, 0));
        tbl.push_back(mk(0,0,1,   0, 0,    0,    5, 0, 1, 1));
        tbl.push_back(mk(1,0,0,   0, 0,    0,    5, 0, 0, 0));
        tbl.push_back(mk(0,1,0,   1, 1,    1,    5, 0, 0, 0));
        tbl.push_back(mk(0,1,0,   2, 2,    2,    5, 0, 0, 0));
        tbl.push_back(mk(0,1,1,   7, 2,    7,    2, 1, 0, 0));
        tbl.push_back(mk(0,0,1,   0, 1,    1,    7, 1, 0, 0));
        tbl.push_back(mk(0,0,1,   0, 0,    0,    1, 1, 0, 0));
        tbl.push_back(mk(0,1,1,   4, 1,    4,    1, 0, 0, 1));
        tbl.push_back(mk(0,0,0,   0, 1,    4,    1, 0, 0, 1));
        tbl.push_back(mk(1,1,0,   9, 0,    0,    1, 0, 0, 0));
        tbl.push_back(mk(0,1,0,  10, 1,   10,    1, 0, 0, 0));
        tbl.push_back(mk(0,1,0,  20, 2,   20,    1, 0, 0, 0));
        tbl.push_back(mk(0,1,0,  30, 3,   30,    1, 0, 0, 0));
        tbl.push_back(mk(0,1,0,  40, 4,   40,    1, 0, 0, 0));
        tbl.push_back(mk(0,1,1,  50, 4,   50,   40, 1, 0, 0));
        tbl.push_back(mk(0,0,1,   0, 3,   30,   50, 1, 0, 0));

        model_reset();
        repeat (2) @(posedge clk);
        #1 chk_all("reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk) rst_n = 1'b1;

        foreach (tbl[i]) begin
            apply(tbl[i].clr, tbl[i].psh, tbl[i].pp, tbl[i].din);
            chk_all($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].top, tbl[i].dout,
                    tbl[i].dv, tbl[i].ovf, tbl[i].unf);
        end

        // async reset lands between edges while a pop strobe and an underflow are live
        apply(1, 0, 0, 0);
        apply(0, 0, 1, 0);
        apply(0, 1, 0, 11);
        apply(0, 1, 0, 22);
        apply(0, 1, 0, 33);
        apply(0, 0, 1, 0);
        chk_all("pre_rst", 2, 22, 33, 1, 0, 1);
        @(negedge clk);
        push = 1'b1; pop = 1'b0; din = 8'sd44;
        #2 rst_n = 1'b0;
        #1 chk_all("mid_rst", 0, 0, 0, 0, 0, 0);
        model_reset();
        @(posedge clk);
        #1 chk_all("held_rst", 0, 0, 0, 0, 0, 0);
        @(negedge clk) begin rst_n = 1'b1; push = 1'b0; end

        for (int i = 0; i < 400; i++) begin
            bit c, p, o;
            c = ($urandom_range(0, 31) == 0);
            p = $urandom_range(0, 1) == 1;
            o = $urandom_range(0, 2) == 0;
            apply(c, p, o, int'($urandom_range(0, 255)) - 128);
            chk_all($sformatf("rnd%0d", i), q.size(), q.size() > 0 ? q[q.size()-1] : 0,
                    dout_m, dv_m, ovf_m, unf_m);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
